// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and tick helpers
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  function automatic int mid_tick(input int oversample);
    return oversample / 2 - 1;
  endfunction

  localparam int MID_TICK = mid_tick(OVERSAMPLE_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x-oversampled 8N1 UART receiver with one-entry valid/ready output
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 uart_samplig_clk,
  input  logic                 reset,
  input  logic                 RsRx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int MID = mid_tick(OVERSAMPLE);

  localparam logic [CW-1:0] T_LO   = CW'(MID - 1);
  localparam logic [CW-1:0] T_MID  = CW'(MID);
  localparam logic [CW-1:0] T_HI   = CW'(MID + 1);
  localparam logic [CW-1:0] T_DEC  = CW'(MID + 2);
  localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t              state, next_state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   rx_s, s_lo, s_mid, maj;
  logic                   deliver, drop, fe_hit;

  uart_rx_sync u_sync (
    .clk   (uart_samplig_clk),
    .rst_n (reset),
    .d     (RsRx),
    .q     (rx_s)
  );

  always_ff @(posedge uart_samplig_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!rx_s) next_state = ST_START;
      ST_START: begin
        if (cnt == T_DEC && maj)  next_state = ST_IDLE;
        else if (cnt == T_LAST)   next_state = ST_DATA;
      end
      ST_DATA:  if (cnt == T_LAST && bit_idx == B_LAST) next_state = ST_STOP;
      ST_STOP:  if (cnt == T_DEC) next_state = maj ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // The stop decision either delivers the byte or flags a framing error, never both.
  always_comb begin
    deliver = 1'b0;
    fe_hit  = 1'b0;
    if (state == ST_STOP && cnt == T_DEC) begin
      deliver = maj;
      fe_hit  = !maj;
    end
    drop = deliver && valid && !ready;
  end

  always_ff @(posedge uart_samplig_clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      s_lo      <= 1'b1;
      s_mid     <= 1'b1;
      maj       <= 1'b1;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state == ST_IDLE || next_state == ST_IDLE || next_state == ST_BREAK) cnt <= '0;
      else                                                                     cnt <= cnt + 1'b1;

      if (state != ST_DATA)  bit_idx <= '0;
      else if (cnt == T_LAST) bit_idx <= (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;

      if (cnt == T_LO)  s_lo  <= rx_s;
      if (cnt == T_MID) s_mid <= rx_s;
      if (cnt == T_HI)  maj   <= (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);

      if (state == ST_DATA && cnt == T_DEC) shreg[bit_idx] <= maj;

      frame_err <= fe_hit;
      overrun   <= drop;

      if (deliver && (!valid || ready)) begin
        data_out <= shreg;
        valid    <= 1'b1;
      end else if (!deliver && valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed and random frame checks of uart_receiver against a frame-level model
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] dout;
  logic       vld, fe, ov;

  uart_receiver dut (
    .uart_samplig_clk (clk),
    .reset            (rst_n),
    .RsRx             (rx),
    .data_out         (dout),
    .valid            (vld),
    .ready            (rdy),
    .frame_err        (fe),
    .overrun          (ov)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, vhi_cnt = 0;
  int rise_cyc = -1, ov_cyc = -1, fall_cyc = 0;
  int fe0, ov0, vh0;
  logic vld_d = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (vld && rdy) got_q.push_back(dout);
      if (vld) vhi_cnt++;
      if (vld && !vld_d) rise_cyc = cyc;
      if (fe) fe_cnt++;
      if (ov) begin
        ov_cnt++;
        ov_cyc = cyc;
      end
      if (fe && ov) both_cnt++;
    end
    vld_d = vld;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vh0 = vhi_cnt;
  endtask

  // One 8N1 frame, LSB first, 16 ticks per bit; stop length and level are selectable.
  task automatic send_frame(input logic [7:0] b, input int stop_ticks, input logic stop_val);
    fall_cyc = cyc;
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(16);
    end
    rx = stop_val;
    step(stop_ticks);
    rx = 1'b1;
  endtask

  // Frame-level model: a well-formed frame with ready held high yields exactly its byte.
  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int gap;

    #1;
    check("reset_valid", vld, 1'b0);
    check("reset_data", dout, 8'h00);
    check("reset_fe", fe, 1'b0);
    check("reset_ov", ov, 1'b0);
    step(3);
    rst_n = 1'b1;
    rdy = 1'b1;
    step(10);

    snap();
    send_frame(8'hA5, 16, 1'b1);
    expect_byte(8'hA5);
    step(20);
    check("a5_latency", rise_cyc - fall_cyc, 157);
    check("a5_valid_width", vhi_cnt - vh0, 1);
    check("a5_fe", fe_cnt - fe0, 0);
    check("a5_ov", ov_cnt - ov0, 0);
    check_rx("a5_data");

    snap();
    send_frame(8'h00, 10, 1'b1);
    expect_byte(8'h00);
    send_frame(8'hFF, 16, 1'b1);
    expect_byte(8'hFF);
    step(20);
    check("b2b_fe", fe_cnt - fe0, 0);
    check("b2b_ov", ov_cnt - ov0, 0);
    check_rx("b2b_data");

    snap();
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(40);
    check("glitch_valid", vhi_cnt - vh0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_ov", ov_cnt - ov0, 0);
    send_frame(8'h5A, 16, 1'b1);
    expect_byte(8'h5A);
    step(20);
    check_rx("glitch_5a");

    snap();
    send_frame(8'h3C, 16 + 40 * 16, 1'b0);
    step(40);
    check("break_fe", fe_cnt - fe0, 1);
    check("break_valid", vhi_cnt - vh0, 0);
    check("break_ov", ov_cnt - ov0, 0);
    send_frame(8'h81, 16, 1'b1);
    expect_byte(8'h81);
    step(20);
    check("break_fe_after", fe_cnt - fe0, 1);
    check_rx("break_81");

    snap();
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      gap = $urandom_range(0, 10);
      send_frame(b, 16, 1'b1);
      expect_byte(b);
      step(gap);
    end
    step(30);
    check("rand_fe", fe_cnt - fe0, 0);
    check("rand_ov", ov_cnt - ov0, 0);
    check_rx("rand_data");

    snap();
    rdy = 1'b0;
    send_frame(8'h11, 16, 1'b1);
    step(5);
    send_frame(8'h22, 16, 1'b1);
    step(20);
    check("ovr_valid", vld, 1'b1);
    check("ovr_data", dout, 8'h11);
    check("ovr_count", ov_cnt - ov0, 1);
    check("ovr_edge", ov_cyc - fall_cyc, 157);
    check("ovr_fe", fe_cnt - fe0, 0);
    rdy = 1'b1;
    expect_byte(8'h11);
    step(1);
    rdy = 1'b0;
    step(2);
    check("ovr_cleared", vld, 1'b0);
    check("ovr_hold", dout, 8'h11);
    check_rx("ovr_take");

    rdy = 1'b1;
    snap();
    b = 8'h77;
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      step(16);
    end
    rx = b[4];
    step(8);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("rst_valid", vld, 1'b0);
    check("rst_data", dout, 8'h00);
    check("rst_fe", fe, 1'b0);
    check("rst_ov", ov, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(200);
    check("rst_no_valid", vhi_cnt - vh0, 0);
    check("rst_no_fe", fe_cnt - fe0, 0);
    check_rx("rst_nothing");
    send_frame(8'hC3, 16, 1'b1);
    expect_byte(8'hC3);
    step(20);
    check_rx("rst_c3");

    check("fe_ov_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
